// File: rtl/mul_acc_stage.sv
// mul_acc_stage
//   Accumulates batches of signed products from the 32-bit multiplier stage
//   into a wide signed sum, presented on a valid/ready output register.
//   A batch closes after ACC_LEN products or on an accepted beat with in_last.
//   If the output register is still occupied when a batch closes, the
//   finished sum parks in the accumulator (DRAIN) and in_ready drops, so the
//   upstream ap_start gating never loses a product.
//
// Ports
//   ap_clk, ap_rst        clock (rising edge), async active-high reset
//   in_valid/in_ready     product handshake (ap_done / ap_start gate)
//   in_data [DATA_W]      signed product
//   in_last               close the current batch on this beat
//   clear                 synchronous abort of the batch in progress
//   out_valid/out_ready   sum handshake
//   out_data [ACC_W]      signed batch sum
//   out_count [CNT_W]     number of products in out_data
//   ovf                   sticky signed-overflow flag
//
// Build option
//   MUL_ACC_STAGE_SAT_EN  defined: saturate on overflow; undefined: wrap.

module mul_acc_stage #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 48,
    parameter int ACC_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              ovf
);

    typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   out_data_nxt;
    logic [CNT_W-1:0]   out_count_nxt;
    logic               out_valid_nxt;
    logic               ovf_nxt;

    logic [ACC_W-1:0]   ext, raw, sum;
    logic [CNT_W-1:0]   cnt_n;
    logic               add_ovf, last_beat, fire, out_take, slot_free;

    // Signed cast before widening gives sign extension.
    assign ext     = ACC_W'($signed(in_data));
    assign raw     = acc + ext;
    assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef MUL_ACC_STAGE_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // On overflow both operands share a sign, so acc's sign picks the rail.
    assign sum = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
    assign sum = raw;
`endif

    assign cnt_n     = cnt + 1'b1;
    assign last_beat = (cnt_n == CNT_W'(ACC_LEN)) || in_last;
    assign in_ready  = (state == ST_ACCUM) && !clear;
    assign fire      = in_valid && in_ready;
    assign out_take  = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;

        // A taken sum empties the slot unless something reloads it below.
        if (out_take)
            out_valid_nxt = 1'b0;

        if (clear) begin
            // Output register keeps its sum; only the batch in flight is dropped.
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            state_nxt = ST_ACCUM;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (fire) begin
                        if (add_ovf)
                            ovf_nxt = 1'b1;
                        if (last_beat && slot_free) begin
                            out_data_nxt  = sum;
                            out_count_nxt = cnt_n;
                            out_valid_nxt = 1'b1;
                            acc_nxt       = '0;
                            cnt_nxt       = '0;
                        end else begin
                            acc_nxt = sum;
                            cnt_nxt = cnt_n;
                            if (last_beat)
                                state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_take) begin
                        out_data_nxt  = acc;
                        out_count_nxt = cnt;
                        out_valid_nxt = 1'b1;
                        acc_nxt       = '0;
                        cnt_nxt       = '0;
                        state_nxt     = ST_ACCUM;
                    end
                end
                default: state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
        end
    end

endmodule

// File: tb/tb_mul_acc_stage.sv
// Testbench for mul_acc_stage: directed test-plan steps followed by random
// traffic, all checked against a queue-based model of completed batch sums.

module tb_mul_acc_stage;

    localparam int DATA_W  = 32;
    localparam int ACC_W   = 32;
    localparam int ACC_LEN = 4;
    localparam int CNT_W   = 8;

    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));
    localparam longint AMOD = 64'sd1 <<< ACC_W;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              ovf;

    mul_acc_stage #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;

    // Model: running batch value and length, plus the list of finished sums
    // not yet consumed (at most two: one presented, one waiting).
    longint acc_m;
    int     cnt_m;
    bit     ovf_m;
    longint q_sum[$];
    int     q_cnt[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc_m = 0;
        cnt_m = 0;
        ovf_m = 0;
        q_sum.delete();
        q_cnt.delete();
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the
    // model at the edge, check outputs 1 time unit after it.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit l,
                        input bit clr, input bit ordy);
        bit     exp_rdy, hs, pend;
        longint s;
        logic [ACC_W-1:0] e;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        clear     = clr;
        out_ready = ordy;
        #2;
        exp_rdy = (q_sum.size() < 2) && !clr;
        chk("in_ready", in_ready, exp_rdy);
        @(posedge ap_clk);
        hs   = (q_sum.size() > 0) && ordy;
        pend = (q_sum.size() == 2);
        if (hs) begin
            void'(q_sum.pop_front());
            void'(q_cnt.pop_front());
        end
        if (clr) begin
            acc_m = 0;
            cnt_m = 0;
            ovf_m = 0;
            if (pend) begin
                void'(q_sum.pop_back());
                void'(q_cnt.pop_back());
            end
        end else if (v && exp_rdy) begin
            s = acc_m + longint'($signed(d));
            if (s > AMAX || s < AMIN) begin
                ovf_m = 1;
`ifdef MUL_ACC_STAGE_SAT_EN
                s = (s > AMAX) ? AMAX : AMIN;
`else
                s = (s > AMAX) ? s - AMOD : s + AMOD;
`endif
            end
            cnt_m++;
            if (cnt_m == ACC_LEN || l) begin
                q_sum.push_back(s);
                q_cnt.push_back(cnt_m);
                acc_m = 0;
                cnt_m = 0;
            end else begin
                acc_m = s;
            end
        end
        #1;
        chk("out_valid", out_valid, q_sum.size() > 0);
        if (q_sum.size() > 0) begin
            e = q_sum[0][ACC_W-1:0];
            chk("out_data", out_data, e);
            chk("out_count", out_count, q_cnt[0]);
        end
        chk("ovf", ovf, ovf_m);
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input bit l, input bit ordy);
        step(1'b1, d, l, 1'b0, ordy);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) idle(1'b1);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_ovf", ovf, 0);
        #9 ap_rst = 1'b0;

        // Basic batch of four.
        beat(3, 0, 1); beat(-5, 0, 1); beat(7, 0, 1); beat(100, 0, 1);
        chk("tp_sum105", out_data, 105);
        chk("tp_cnt4", out_count, 4);
        chk("tp_ovf0", ovf, 0);
        idle(1);

        // in_last without accept is ignored; in_last on a beat closes early.
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        beat(10, 0, 1); beat(20, 1, 1);
        chk("tp_sum30", out_data, 30);
        chk("tp_cnt2", out_count, 2);
        beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 1);
        chk("tp_sum4", out_data, 4);
        flush();

        // Back-pressure: second batch parks in DRAIN.
        repeat (4) beat(1, 0, 0);
        repeat (4) beat(2, 0, 0);
        idle(0);
        chk("drain_hold", out_data, 4);
        chk("drain_rdy0", in_ready, 0);
        idle(1);
        chk("drain_sum8", out_data, 8);
        chk("drain_cnt4", out_count, 4);
        idle(0);
        chk("drain_rdy1", in_ready, 1);
        flush();

        // Final beat coincides with the take of the previous sum: no bubble.
        repeat (4) beat(1, 0, 0);
        repeat (3) beat(2, 0, 0);
        beat(2, 0, 1);
        chk("nobub_valid", out_valid, 1);
        chk("nobub_sum8", out_data, 8);
        flush();

        // clear in DRAIN drops the parked batch, keeps the presented one.
        repeat (4) beat(3, 0, 0);
        repeat (4) beat(4, 0, 0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_keep", out_data, 12);
        idle(1);
        chk("clr_drop", out_valid, 0);
        flush();

        // Signed overflow, sticky until clear; continue after overflow.
        beat(32'h7FFF_FFFF, 0, 1); beat(1, 1, 1);
`ifdef MUL_ACC_STAGE_SAT_EN
        chk("ovf_sat", out_data, 32'h7FFF_FFFF);
`else
        chk("ovf_wrap", out_data, 32'h8000_0000);
`endif
        chk("ovf_set", ovf, 1);
        beat(5, 1, 1);
        chk("ovf_sticky", ovf, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clr", ovf, 0);
        beat(32'h8000_0000, 0, 1); beat(-1, 0, 1); beat(-1, 1, 1);
        flush();

        // Async reset mid-batch with a held output.
        repeat (4) beat(1, 0, 0);
        beat(5, 0, 0); beat(5, 0, 0);
        ap_rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_count", out_count, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (4) beat(5, 0, 1);
        chk("arst_sum20", out_data, 20);
        flush();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [DATA_W-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom)
                                            : DATA_W'($signed($urandom_range(0, 200)) - 100);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 30) == 0, $urandom_range(0, 2) != 0);
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
